dsam_channel_sequencer: RTL and testbench
=========================================

DSAM_CHANNEL_SEQUENCER -- requirements
Module: dsam_channel_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample and encoder word width.
REQ-002 SHALL have parameter CHANNELS, default 256, channels per frame, power of two, at least 2.
REQ-003 SHALL have parameter ENC_LATENCY, default 1, cycles from enc_en sample to encoder output.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins sequencing from IDLE.
REQ-007 SHALL have port stop, input, 1, a one-cycle pulse that ends sequencing at the next frame boundary.
REQ-008 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-009 SHALL have port s_ready, output, 1, upstream sample ready.
REQ-010 SHALL have port s_data, input, DATA_WIDTH, upstream sample.
REQ-011 SHALL have port s_last, input, 1, source marker for the last channel of a frame.
REQ-012 SHALL have port enc_in, output, DATA_WIDTH, sample to the encoder.
REQ-013 SHALL have port enc_en, output, 1, encoder advance strobe.
REQ-014 SHALL have port enc_clr, output, 1, one-cycle encoder/FIFO history clear.
REQ-015 SHALL have port m_valid, output, 1, encoder output valid tag.
REQ-016 SHALL have port m_chan, output, log2(CHANNELS), channel of the current encoder output.
REQ-017 SHALL have port m_prime, output, 1, high when the output belongs to the first (raw) frame.
REQ-018 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-019 SHALL have port sync_err, output, 1, sticky framing-error flag.

Function
REQ-020 SHALL implement the states IDLE, CLEAR, PRIME, RUN and DRAIN.
REQ-021 SHALL go IDLE->CLEAR on start, CLEAR->PRIME after one cycle, PRIME->RUN after CHANNELS accepted samples, RUN->DRAIN on a pending stop at frame end, and DRAIN->IDLE after ENC_LATENCY cycles.
REQ-022 SHALL drive s_ready high only in PRIME and RUN.
REQ-023 SHALL accept a sample on s_valid&&s_ready, which registers enc_in<=s_data and pulses enc_en for one cycle.
REQ-024 SHALL pulse enc_clr high for exactly the CLEAR cycle and hold enc_en low in that cycle.
REQ-025 SHALL use a channel counter that resets to 0, increments per accepted sample, and wraps from CHANNELS-1 to 0.
REQ-026 SHALL delay the channel and prime tags through an ENC_LATENCY-deep pipe aligned with enc_en, producing m_valid, m_chan and m_prime.
REQ-027 SHALL set m_prime for every sample accepted in PRIME and clear it for every sample accepted in RUN.
REQ-028 SHALL, if an accepted s_last does not coincide with counter CHANNELS-1 or an accepted sample at counter CHANNELS-1 lacks s_last, set sync_err and go to CLEAR, discarding the partial frame history.
REQ-029 SHALL clear sync_err only on start or reset.
REQ-030 SHALL latch stop into stop_pend, act on it only when the counter wraps, and, if stop arrives in PRIME, complete priming before DRAIN.
REQ-031 SHALL give start priority when start and stop are asserted in the same cycle in IDLE, and ignore start outside IDLE.
REQ-032 SHALL continue to drain the m_valid pipe in DRAIN and accept no new samples there.

Reset
REQ-033 SHALL, while reset is low, force state IDLE, counter 0, stop_pend 0, sync_err 0, and s_ready, enc_en, enc_clr, m_valid, m_prime, m_chan, busy and enc_in all 0.
REQ-034 SHALL, on reset asserted mid-frame, abandon the frame immediately with no drain, and require a start after release.

Configuration
REQ-035 SHALL, with DSAM_SEQ_FRAME_CNT_EN defined, add output frame_cnt (32-bit), zeroed on start and incremented on each completed RUN frame and saturating at all ones.
REQ-036 SHALL, without DSAM_SEQ_FRAME_CNT_EN, omit the frame_cnt port and its register entirely.

Structure
REQ-037 SHALL place the state enumerated type and the function deriving the channel-index width from CHANNELS in the shared package dsam_pkg.
REQ-038 SHALL contain one natural sub-module, dsam_tag_pipe, the ENC_LATENCY-deep valid/channel/prime delay line.

Verification
REQ-039 SHALL verify priming: with CHANNELS=4 and ENC_LATENCY=1, start then 4 samples with s_last on the 4th gives m_prime=1 with m_chan 0,1,2,3 one cycle after each enc_en, then m_prime=0.
REQ-040 SHALL verify back-pressure: with s_valid toggled randomly, enc_en pulses only on a handshake and m_chan increments without gaps.
REQ-041 SHALL verify a framing error: s_last at channel 2 of 4 sets sync_err=1, pulses enc_clr next cycle, and the following frame has m_prime=1.
REQ-042 SHALL verify stop: a stop pulse at channel 1 of RUN completes channels 2 and 3, then gives busy=0 after ENC_LATENCY cycles, with s_ready=0 throughout DRAIN.
REQ-043 SHALL verify reset mid-RUN: reset low at channel 2 drives all outputs 0 asynchronously and leaves state IDLE after release.
REQ-044 SHALL verify the frame counter with DSAM_SEQ_FRAME_CNT_EN: 3 RUN frames after priming give frame_cnt=3, and frame_cnt is 0 after a new start.

Source files
------------

// File: rtl/dsam_pkg.sv
// Shared types and helpers for the DSAM channel sequencer.
// State codes are plain localparams so legacy netlists can match the encoding.
package dsam_pkg;

    typedef logic [2:0] dsam_state_t;

    localparam dsam_state_t ST_IDLE  = 3'd0;
    localparam dsam_state_t ST_CLEAR = 3'd1;
    localparam dsam_state_t ST_PRIME = 3'd2;
    localparam dsam_state_t ST_RUN   = 3'd3;
    localparam dsam_state_t ST_DRAIN = 3'd4;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dsam_tag_pipe.sv
// Delay line for the valid/channel/prime tags, matching the encoder latency.
module dsam_tag_pipe #(
    parameter int LATENCY = 1,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] in_chan,
    input  logic          in_prime,
    output logic          out_valid,
    output logic [CW-1:0] out_chan,
    output logic          out_prime
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] prime_q;
    logic [CW-1:0]      chan_q [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            prime_q <= '0;
            for (int i = 0; i < LATENCY; i++) chan_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            prime_q[0] <= in_prime;
            chan_q[0]  <= in_chan;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                prime_q[i] <= prime_q[i-1];
                chan_q[i]  <= chan_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_prime = prime_q[LATENCY-1];
    assign out_chan  = chan_q[LATENCY-1];

endmodule

// File: rtl/dsam_channel_sequencer.sv
// Frame sequencer feeding a delta-sigma encoder; DSAM_SEQ_FRAME_CNT_EN adds frame_cnt.
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | one-cycle encoder/FIFO history clear
//   PRIME | first (raw) frame, outputs tagged m_prime
//   RUN   | steady-state frames
//   DRAIN | flushing the tag pipe before returning to IDLE
module dsam_channel_sequencer
    import dsam_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 256,
    parameter int ENC_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_last,
    output logic [DATA_WIDTH-1:0]           enc_in,
    output logic                            enc_en,
    output logic                            enc_clr,
    output logic                            m_valid,
    output logic [chan_width(CHANNELS)-1:0] m_chan,
    output logic                            m_prime,
    output logic                            busy,
    output logic                            sync_err
`ifdef DSAM_SEQ_FRAME_CNT_EN
    ,
    output logic [31:0]                     frame_cnt
`endif
);

    localparam int CW = chan_width(CHANNELS);
    localparam int DW = (ENC_LATENCY > 1) ? $clog2(ENC_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    dsam_state_t   state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] drain_cnt;
    logic          stop_pend;
    logic [CW-1:0] tag_chan;
    logic          tag_prime;
    logic          accept;
    logic          frame_err;

    assign s_ready   = (state == ST_PRIME) || (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign enc_clr   = (state == ST_CLEAR);
    assign accept    = s_valid && s_ready;
    assign frame_err = s_last != (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            stop_pend <= 1'b0;
            sync_err  <= 1'b0;
            enc_en    <= 1'b0;
            enc_in    <= '0;
            tag_chan  <= '0;
            tag_prime <= 1'b0;
        end else begin
            enc_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CLEAR;
                        sync_err  <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_PRIME;
                    cnt   <= '0;
                    if (stop) stop_pend <= 1'b1;
                end
                ST_PRIME, ST_RUN: begin
                    if (stop) stop_pend <= 1'b1;
                    if (accept) begin
                        if (frame_err) begin
                            // Misframed sample is dropped; CLEAR wipes the partial history.
                            sync_err <= 1'b1;
                            state    <= ST_CLEAR;
                            cnt      <= '0;
                        end else begin
                            enc_en    <= 1'b1;
                            enc_in    <= s_data;
                            tag_chan  <= cnt;
                            tag_prime <= (state == ST_PRIME);
                            cnt       <= cnt + CW'(1);
                            if (cnt == LAST) begin
                                if (stop_pend || stop) begin
                                    state     <= ST_DRAIN;
                                    stop_pend <= 1'b0;
                                    drain_cnt <= DW'(ENC_LATENCY - 1);
                                end else begin
                                    state <= ST_RUN;
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else                 drain_cnt <= drain_cnt - DW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DSAM_SEQ_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_cnt <= '0;
        else if (state == ST_IDLE && start)
            frame_cnt <= '0;
        else if (state == ST_RUN && accept && !frame_err && cnt == LAST && frame_cnt != '1)
            frame_cnt <= frame_cnt + 32'd1;
    end
`else
    // Frame counting is not built in this configuration.
`endif

    dsam_tag_pipe #(
        .LATENCY (ENC_LATENCY),
        .CW      (CW)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (enc_en),
        .in_chan   (tag_chan),
        .in_prime  (tag_prime),
        .out_valid (m_valid),
        .out_chan  (m_chan),
        .out_prime (m_prime)
    );

endmodule

// File: tb/tb_dsam_channel_sequencer.sv
// Randomized bench for dsam_channel_sequencer against a per-cycle behavioural model.
module tb_dsam_channel_sequencer;

    localparam int DW  = 16;
    localparam int CH  = 4;
    localparam int LAT = 1;
    localparam int CW  = 2;

    // Model phases
    localparam int P_IDLE = 0, P_CLEAR = 1, P_PRIME = 2, P_RUN = 3, P_DRAIN = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop, s_valid, s_last;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] enc_in;
    logic          enc_en, enc_clr, m_valid, m_prime, busy, sync_err;
    logic [CW-1:0] m_chan;
`ifdef DSAM_SEQ_FRAME_CNT_EN
    logic [31:0]   frame_cnt;
`endif

    dsam_channel_sequencer #(
        .DATA_WIDTH  (DW),
        .CHANNELS    (CH),
        .ENC_LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .enc_in   (enc_in),
        .enc_en   (enc_en),
        .enc_clr  (enc_clr),
        .m_valid  (m_valid),
        .m_chan   (m_chan),
        .m_prime  (m_prime),
        .busy     (busy),
        .sync_err (sync_err)
`ifdef DSAM_SEQ_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit v;
        int ch;
        bit pr;
    } tag_t;

    int            phase, pos, drain_left;
    bit            stop_m, err_m, en_m, pr_m;
    int            ch_m;
    logic [DW-1:0] data_m;
    longint        fcnt;
    tag_t          tq[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = P_IDLE; pos = 0; drain_left = 0;
        stop_m = 0; err_m = 0; en_m = 0; pr_m = 0; ch_m = 0; data_m = '0; fcnt = 0;
        tq.delete();
        repeat (LAT) tq.push_back('{0, 0, 0});
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_s_ready"}, s_ready, 0);
        check_val({tag, "_busy"},    busy,    0);
        check_val({tag, "_enc_en"},  enc_en,  0);
        check_val({tag, "_enc_clr"}, enc_clr, 0);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_chan"},  m_chan,  0);
        check_val({tag, "_m_prime"}, m_prime, 0);
        check_val({tag, "_enc_in"},  enc_in,  0);
        check_val({tag, "_sync_err"}, sync_err, 0);
    endtask

    task automatic check_outputs();
        check_val("s_ready", s_ready, (phase == P_PRIME || phase == P_RUN));
        check_val("busy",    busy,    (phase != P_IDLE));
        check_val("enc_clr", enc_clr, (phase == P_CLEAR));
        check_val("enc_en",  enc_en,  en_m);
        check_val("sync_err", sync_err, err_m);
        if (en_m) check_val("enc_in", enc_in, data_m);
        check_val("m_valid", m_valid, tq[0].v);
        if (tq[0].v) begin
            check_val("m_chan",  m_chan,  tq[0].ch);
            check_val("m_prime", m_prime, tq[0].pr);
        end
`ifdef DSAM_SEQ_FRAME_CNT_EN
        check_val("frame_cnt", frame_cnt, fcnt[31:0]);
`endif
    endtask

    // One clock: check at the falling edge, drive new inputs, advance the model.
    task automatic tick(input bit st, input bit sp, input int vpct, input int err_at);
        bit hs;
        @(negedge clk);
        check_outputs();
        void'(tq.pop_front());
        tq.push_back('{en_m, ch_m, pr_m});

        start   = st;
        stop    = sp;
        s_valid = ($urandom_range(99) < vpct);
        s_data  = DW'($urandom);
        s_last  = (err_at >= 0) ? (pos == err_at) : (pos == CH - 1);

        hs   = s_valid && (phase == P_PRIME || phase == P_RUN);
        en_m = 0;
        case (phase)
            P_IDLE: if (st) begin
                phase = P_CLEAR; err_m = 0; stop_m = 0; fcnt = 0;
            end
            P_CLEAR: begin
                phase = P_PRIME; pos = 0;
                if (sp) stop_m = 1;
            end
            P_PRIME, P_RUN: begin
                if (sp) stop_m = 1;
                if (hs) begin
                    if (s_last != (pos == CH - 1)) begin
                        err_m = 1; phase = P_CLEAR; pos = 0;
                    end else begin
                        en_m = 1; data_m = s_data; ch_m = pos; pr_m = (phase == P_PRIME);
                        if (pos == CH - 1) begin
                            pos = 0;
                            if (phase == P_RUN && fcnt < 64'hFFFF_FFFF) fcnt++;
                            if (stop_m) begin
                                phase = P_DRAIN; drain_left = LAT; stop_m = 0;
                            end else begin
                                phase = P_RUN;
                            end
                        end else begin
                            pos++;
                        end
                    end
                end
            end
            default: begin
                drain_left--;
                if (drain_left == 0) phase = P_IDLE;
            end
        endcase
    endtask

    task automatic seek(input string tag, input int ph, input int p, input int vpct);
        for (int k = 0; k < 300 && !(phase == ph && pos == p); k++) tick(0, 0, vpct, -1);
        check_val(tag, (phase == ph && pos == p), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300 && phase != P_IDLE; k++) tick(0, 0, 50, -1);
        tick(0, 0, 0, -1);
        check_val(tag, busy, 0);
    endtask

    initial begin
        reset = 0; start = 0; stop = 0; s_valid = 0; s_last = 0; s_data = '0;
        model_reset();
        #3 check_zero("por");
        repeat (2) tick(0, 0, 0, -1);
        reset = 1;

        // Priming with a steady source, then a few run frames and a stop at channel 1
        tick(1, 0, 100, -1);
        repeat (3 * CH + CH + 2) tick(0, 0, 100, -1);
        seek("seek_stop_a", P_RUN, 1, 70);
        tick(0, 1, 70, -1);
        wait_idle("drain_a");

        // start+stop together favours start; stop during PRIME finishes priming first
        tick(1, 1, 100, -1);
        seek("seek_prime", P_PRIME, 1, 100);
        tick(0, 1, 100, -1);
        wait_idle("drain_prime");

        // Framing error: s_last at channel 2 in RUN
        tick(1, 0, 100, -1);
        seek("seek_err", P_RUN, 0, 80);
        for (int k = 0; k < 100 && !err_m; k++) tick(0, 0, 80, 2);
        check_val("err_hit", err_m, 1);
        repeat (3 * CH) tick(0, 0, 80, -1);
        seek("seek_stop_b", P_RUN, 1, 80);
        tick(0, 1, 80, -1);
        wait_idle("drain_b");

        // Long randomized back-pressure run
        tick(1, 0, 100, -1);
        repeat (80) tick(0, 0, $urandom_range(20, 100), -1);
        seek("seek_stop_c", P_RUN, 1, 60);
        tick(0, 1, 60, -1);
        wait_idle("drain_c");

        // Reset mid-RUN at channel 2
        tick(1, 0, 100, -1);
        repeat (CH + 2) tick(0, 0, 100, -1);
        seek("seek_rst", P_RUN, 2, 100);
        #2 reset = 0;
        #1 check_zero("rst_mid");
        @(posedge clk);
        #1 check_zero("rst_hold");
        @(negedge clk);
        reset = 1;
        model_reset();
        repeat (5) tick(0, 0, 100, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
